// File: rtl/i2s_codec_port.sv
// i2s_codec_port: I2S target endpoint. BCLK/LRCLK come from the master and are
// oversampled in CLK_I. The DAC stream on SDATA_I is deserialised into matched
// left/right words. Local left/right words are serialised onto SDATA_O with the
// usual one-BCLK delay after each LRCLK change.
//
// state       | meaning
// ------------+----------------------------------------------------------------
// ST_UNLOCKED | no LRCLK transition seen since reset; SDATA_O held 0, no pulses
// ST_LEFT     | inside a left-channel slot (LRCLK = 0)
// ST_RIGHT    | inside a right-channel slot (LRCLK = 1)
module i2s_codec_port #(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  BCLK_I,
  input  logic                  LRCLK_I,
  input  logic                  SDATA_I,
  output logic                  SDATA_O,
  input  logic [DATA_WIDTH-1:0] D_L_I,
  input  logic [DATA_WIDTH-1:0] D_R_I,
  output logic                  TX_REQ_O,
  output logic [DATA_WIDTH-1:0] D_L_O,
  output logic [DATA_WIDTH-1:0] D_R_O,
  output logic                  VALID_O,
  output logic                  ERR_O,
  output logic                  LOCK_O
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LEFT     = 2'd1,
    ST_RIGHT    = 2'd2
  } state_t;

  // front end
  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lr_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   bclk_s;
  logic                   lr_s;
  logic                   sd_s;
  logic                   bclk_d;
  logic                   bclk_rise;
  logic                   bclk_fall;

  // LRCLK tracking
  logic lr_q;
  logic lr_seen;
  logic lr_chg;
  logic frame_start;

  // FSM
  state_t state;
  state_t state_nxt;
  logic   slot_err;
  logic   locked;

  // receive path
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [DATA_WIDTH-1:0] rx_word;
  logic [DATA_WIDTH-1:0] left_hold;
  logic [CNT_W-1:0]      rx_cnt;
  logic                  left_ok;
  logic                  rx_bit;
  logic                  rx_done;

  // transmit path
  logic [DATA_WIDTH-1:0] tx_hold_r;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [CNT_W-1:0]      tx_cnt;

  // Bring the three I2S pins into CLK_I through equal-depth synchronisers so
  // LRCLK/SDATA line up with the BCLK edge that samples them.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      sd_sync   <= '0;
      bclk_d    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], BCLK_I};
      lr_sync   <= {lr_sync[SYNC_STAGES-2:0], LRCLK_I};
      sd_sync   <= {sd_sync[SYNC_STAGES-2:0], SDATA_I};
      bclk_d    <= bclk_s;
    end
  end

  assign bclk_s    = bclk_sync[SYNC_STAGES-1];
  assign lr_s      = lr_sync[SYNC_STAGES-1];
  assign sd_s      = sd_sync[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_d;
  assign bclk_fall = ~bclk_s & bclk_d;

  // Remember LRCLK at each rise; lr_seen masks the first rise after reset so
  // the reset value of lr_q cannot masquerade as a transition.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      lr_q    <= 1'b0;
      lr_seen <= 1'b0;
    end else if (bclk_rise) begin
      lr_q    <= lr_s;
      lr_seen <= 1'b1;
    end
  end

  assign lr_chg      = bclk_rise & lr_seen & (lr_s != lr_q);
  assign frame_start = lr_chg & ~lr_s;

  // State register.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= ST_UNLOCKED;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; a slot that ends before a full word was shifted in is
  // flagged as it closes.
  always_comb begin
    state_nxt = state;
    slot_err  = 1'b0;
    case (state)
      ST_UNLOCKED: begin
        if (lr_chg) begin
          state_nxt = lr_s ? ST_RIGHT : ST_LEFT;
        end
      end
      ST_LEFT, ST_RIGHT: begin
        if (lr_chg) begin
          state_nxt = lr_s ? ST_RIGHT : ST_LEFT;
          slot_err  = (rx_cnt != CNT_FULL);
        end
      end
      default: begin
        state_nxt = ST_UNLOCKED;
      end
    endcase
  end

  assign locked  = (state != ST_UNLOCKED);
  assign rx_bit  = bclk_rise & locked & ~lr_chg & (rx_cnt != CNT_FULL);
  assign rx_done = rx_bit & (rx_cnt == CNT_LAST);
  assign rx_word = {rx_sr[DATA_WIDTH-2:0], sd_s};

  // TX_REQ_O and ERR_O are decoded straight from the LRCLK-change strobe so that
  // the request lines up with the capture edge and an error on the closing
  // right slot lands in the same cycle as the request for the next frame.
  assign TX_REQ_O = frame_start;
  assign ERR_O    = slot_err;

  // Receive: shift MSB-first after the one-bit I2S delay, hold the left word,
  // publish the pair only when the right word of the same frame completes.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      rx_sr     <= '0;
      rx_cnt    <= '0;
      left_hold <= '0;
      left_ok   <= 1'b0;
      D_L_O     <= '0;
      D_R_O     <= '0;
      VALID_O   <= 1'b0;
      LOCK_O    <= 1'b0;
    end else begin
      VALID_O <= 1'b0;
      if (lr_chg) begin
        rx_cnt <= '0;
        LOCK_O <= 1'b1;
        if (frame_start) begin
          left_ok <= 1'b0;
        end
      end else if (rx_bit) begin
        rx_sr  <= rx_word;
        rx_cnt <= rx_cnt + CNT_ONE;
        if (rx_done) begin
          if (state == ST_LEFT) begin
            left_hold <= rx_word;
            left_ok   <= 1'b1;
          end else if (left_ok) begin
            D_L_O   <= left_hold;
            D_R_O   <= rx_word;
            VALID_O <= 1'b1;
            left_ok <= 1'b0;
          end
        end
      end
    end
  end

  // Transmit: both words are captured at frame start; the left word goes
  // straight into the shifter and the right word waits in tx_hold_r. Bits leave
  // on BCLK fall so the master sees the MSB on the second rise of the slot.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      tx_hold_r <= '0;
      tx_sr     <= '0;
      tx_cnt    <= '0;
      SDATA_O   <= 1'b0;
    end else if (lr_chg) begin
      tx_cnt <= '0;
      if (frame_start) begin
        tx_hold_r <= D_R_I;
        tx_sr     <= D_L_I;
      end else begin
        tx_sr <= tx_hold_r;
      end
    end else if (bclk_fall && locked) begin
      SDATA_O <= (tx_cnt != CNT_FULL) & tx_sr[DATA_WIDTH-1];
      tx_sr   <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
      if (tx_cnt != CNT_FULL) begin
        tx_cnt <= tx_cnt + CNT_ONE;
      end
    end
  end

endmodule
